// File: rtl/fir_cfg_sequencer.sv
// AXI-Lite master that checks, programs and launches the FIR engine, then polls for ap_done.
// One AXI transaction per FSM state; the FSM advances only when that transaction completes.
module fir_cfg_sequencer #(
  parameter int unsigned pADDR_WIDTH  = 12,
  parameter int unsigned pDATA_WIDTH  = 32,
  parameter int unsigned Tape_Num     = 11,
  parameter int unsigned POLL_TIMEOUT = 1024,
  parameter int unsigned VERIFY       = 1
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   cfg_start,
  input  logic [pDATA_WIDTH-1:0] cfg_len,
  output logic                   coef_req,
  output logic [3:0]             coef_idx,
  input  logic                   coef_ack,
  input  logic [pDATA_WIDTH-1:0] coef_data,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [1:0]             err_code,
  output logic                   awvalid,
  output logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   awready,
  output logic                   wvalid,
  output logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   wready,
  output logic                   arvalid,
  output logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   arready,
  input  logic                   rvalid,
  input  logic [pDATA_WIDTH-1:0] rdata,
  output logic                   rready
);

  localparam int unsigned CW = $clog2(POLL_TIMEOUT + 1);
  localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = '0;
  localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(12'h010);
  localparam logic [pADDR_WIDTH-1:0] ADDR_TAP  = pADDR_WIDTH'(12'h040);
  localparam logic [3:0]             LAST_IDX  = 4'(Tape_Num - 1);
  localparam logic [CW-1:0]          TMO       = CW'(POLL_TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE, S_CHK, S_LEN, S_FETCH, S_TAPW, S_TAPR, S_NEXT, S_STRT, S_POLL, S_DONE, S_ERR
  } state_e;

  state_e                 state_q, state_d;
  logic                   txn_q, txn_d;
  logic [3:0]             idx_q, idx_d;
  logic [pDATA_WIDTH-1:0] len_q, len_d;
  logic [pDATA_WIDTH-1:0] coef_q, coef_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [1:0]             code_q, code_d;
  logic                   coef_req_q, coef_req_d;
  logic                   awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic [pADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [pDATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                   arvalid_q, arvalid_d, rready_q, rready_d;

  logic [pADDR_WIDTH-1:0] tap_addr_c;
  logic [CW-1:0]          cnt_inc_c;
  logic                   wr_done_c, rd_done_c;

  assign tap_addr_c = ADDR_TAP + pADDR_WIDTH'({idx_q, 2'b00});
  assign cnt_inc_c  = cnt_q + CW'(1);
  assign wr_done_c  = txn_q && (!awvalid_q || awready) && (!wvalid_q || wready);
  assign rd_done_c  = txn_q && rready_q && rvalid;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q    <= S_IDLE;
      txn_q      <= 1'b0;
      idx_q      <= '0;
      len_q      <= '0;
      coef_q     <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= '0;
      coef_req_q <= 1'b0;
      awvalid_q  <= 1'b0;
      awaddr_q   <= '0;
      wvalid_q   <= 1'b0;
      wdata_q    <= '0;
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
      rready_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      txn_q      <= txn_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      coef_q     <= coef_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      code_q     <= code_d;
      coef_req_q <= coef_req_d;
      awvalid_q  <= awvalid_d;
      awaddr_q   <= awaddr_d;
      wvalid_q   <= wvalid_d;
      wdata_q    <= wdata_d;
      arvalid_q  <= arvalid_d;
      araddr_q   <= araddr_d;
      rready_q   <= rready_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    txn_d      = txn_q;
    idx_d      = idx_q;
    len_d      = len_q;
    coef_d     = coef_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    code_d     = code_q;
    coef_req_d = coef_req_q;
    awvalid_d  = awvalid_q;
    awaddr_d   = awaddr_q;
    wvalid_d   = wvalid_q;
    wdata_d    = wdata_q;
    arvalid_d  = arvalid_q;
    araddr_d   = araddr_q;
    rready_d   = rready_q;

    // Channel handshakes are state-independent: only one transaction is ever outstanding.
    if (awvalid_q && awready) awvalid_d = 1'b0;
    if (wvalid_q && wready)   wvalid_d  = 1'b0;
    if (arvalid_q && arready) begin
      arvalid_d = 1'b0;
      rready_d  = 1'b1;
    end
    if (rready_q && rvalid) rready_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          len_d   = cfg_len;
          err_d   = 1'b0;
          code_d  = 2'd0;
          busy_d  = 1'b1;
          state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (!txn_q) begin
          txn_d     = 1'b1;
          arvalid_d = 1'b1;
          araddr_d  = ADDR_CTRL;
        end else if (rd_done_c) begin
          txn_d = 1'b0;
          if (rdata[2]) begin
            state_d = S_LEN;
          end else begin
            err_d   = 1'b1;
            code_d  = 2'd1;
            state_d = S_ERR;
          end
        end
      end
      S_LEN: begin
        if (!txn_q) begin
          txn_d     = 1'b1;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = ADDR_LEN;
          wdata_d   = len_q;
        end else if (wr_done_c) begin
          txn_d   = 1'b0;
          idx_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (!coef_req_q) begin
          coef_req_d = 1'b1;
        end else if (coef_ack) begin
          coef_req_d = 1'b0;
          coef_d     = coef_data;
          state_d    = S_TAPW;
        end
      end
      S_TAPW: begin
        if (!txn_q) begin
          txn_d     = 1'b1;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = tap_addr_c;
          wdata_d   = coef_q;
        end else if (wr_done_c) begin
          txn_d   = 1'b0;
          state_d = (VERIFY != 0) ? S_TAPR : S_NEXT;
        end
      end
      S_TAPR: begin
        if (!txn_q) begin
          txn_d     = 1'b1;
          arvalid_d = 1'b1;
          araddr_d  = tap_addr_c;
        end else if (rd_done_c) begin
          txn_d = 1'b0;
          if (rdata == coef_q) begin
            state_d = S_NEXT;
          end else begin
            err_d   = 1'b1;
            code_d  = 2'd2;
            state_d = S_ERR;
          end
        end
      end
      S_NEXT: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_STRT;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_FETCH;
        end
      end
      S_STRT: begin
        if (!txn_q) begin
          txn_d     = 1'b1;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = ADDR_CTRL;
          wdata_d   = pDATA_WIDTH'(1);
        end else if (wr_done_c) begin
          txn_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_POLL;
        end
      end
      S_POLL: begin
        if (cnt_q != TMO) cnt_d = cnt_inc_c;
        // A read already in flight at expiry is allowed to finish; ap_done on it still wins.
        if (!txn_q) begin
          if (cnt_q >= TMO) begin
            err_d   = 1'b1;
            code_d  = 2'd3;
            state_d = S_ERR;
          end else begin
            txn_d     = 1'b1;
            arvalid_d = 1'b1;
            araddr_d  = ADDR_CTRL;
          end
        end else if (rd_done_c) begin
          txn_d = 1'b0;
          if (rdata[1]) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else if (cnt_inc_c >= TMO) begin
            err_d   = 1'b1;
            code_d  = 2'd3;
            state_d = S_ERR;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_ERR: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign coef_req = coef_req_q;
  assign coef_idx = idx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = code_q;
  assign awvalid  = awvalid_q;
  assign awaddr   = awaddr_q;
  assign wvalid   = wvalid_q;
  assign wdata    = wdata_q;
  assign arvalid  = arvalid_q;
  assign araddr   = araddr_q;
  assign rready   = rready_q;

endmodule

// File: tb/tb_fir_cfg_sequencer.sv
// Bench for fir_cfg_sequencer: randomized-latency FIR AXI-Lite slave and coefficient source,
// with expected transaction lists derived from the configuration sequence rules.
module tb_fir_cfg_sequencer;

  localparam int TAPS = 11;
  localparam int TMO  = 32;
  localparam int MAXD = 5;

  logic        axis_clk, axis_rst_n;
  logic        cfg_start;
  logic [31:0] cfg_len;
  logic        coef_req, coef_ack;
  logic [3:0]  coef_idx;
  logic [31:0] coef_data;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic        awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
  logic [11:0] awaddr, araddr;
  logic [31:0] wdata, rdata;

  fir_cfg_sequencer #(.POLL_TIMEOUT(TMO)) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
    .cfg_start(cfg_start), .cfg_len(cfg_len),
    .coef_req(coef_req), .coef_idx(coef_idx), .coef_ack(coef_ack), .coef_data(coef_data),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wready(wready),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rready(rready)
  );

  initial begin
    axis_clk = 1'b0;
    forever #5 axis_clk = ~axis_clk;
  end

  int cyc = 0;
  always @(posedge axis_clk) cyc <= cyc + 1;

  int ncmp = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    ncmp++;
    assert (obs === exp_v) else begin
      nfail++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp_v);
    end
  endtask

  // Scenario configuration, written by the stimulus; the slave resets itself when scen_id moves.
  int          scen_id = 0;
  bit          cfg_idle;
  int          cfg_done_dly;
  bit          cfg_bad_en;
  logic [11:0] cfg_bad_addr;
  logic [31:0] taps_cur [16];

  // Slave-side state and logs
  int          seen_id;
  logic [31:0] tap_mem [16];
  bit          st_idle, st_done, st_start;
  int          eng_cnt;
  logic [11:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [11:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [11:0] rd_addr[$];
  int          start_wr_cyc, done_pulses, unstable;

  function automatic logic [31:0] rd_value(input logic [11:0] a);
    logic [31:0] v;
    v = 32'h0;
    if (a == 12'h000) v = {29'h0, st_idle, st_done, st_start};
    else if (a >= 12'h040 && a < 12'h080) v = tap_mem[4'((a - 12'h040) >> 2)];
    if (cfg_bad_en && a == cfg_bad_addr) v = v ^ 32'h1;
    return v;
  endfunction

  initial begin
    bit          aw_act, w_act, ar_act, r_pend;
    int          aw_dly, w_dly, ar_dly, r_dly, c_dly;
    logic [11:0] aw_hold, ar_hold, a;
    logic [31:0] w_hold, r_val, d;
    awready = 0; wready = 0; arready = 0; rvalid = 0; rdata = '0;
    coef_ack = 0; coef_data = '0;
    seen_id = 0; aw_act = 0; w_act = 0; ar_act = 0; r_pend = 0; c_dly = -1;
    aw_dly = 0; w_dly = 0; ar_dly = 0; r_dly = 0; r_val = '0;
    aw_hold = '0; ar_hold = '0; w_hold = '0;
    st_idle = 1; st_done = 0; st_start = 0; eng_cnt = -1;
    start_wr_cyc = -1; done_pulses = 0; unstable = 0;
    forever begin
      @(negedge axis_clk);
      if (scen_id != seen_id) begin
        seen_id = scen_id;
        wr_addr.delete(); wr_data.delete(); rd_addr.delete();
        st_idle = cfg_idle; st_done = 0; st_start = 0; eng_cnt = -1;
        start_wr_cyc = -1; done_pulses = 0; unstable = 0;
        for (int i = 0; i < 16; i++) tap_mem[i] = '0;
      end
      if (!axis_rst_n) begin
        awready = 0; wready = 0; arready = 0; rvalid = 0; coef_ack = 0;
        aw_act = 0; w_act = 0; ar_act = 0; r_pend = 0; c_dly = -1;
        wa_q.delete(); wd_q.delete();
        continue;
      end
      if (done) done_pulses++;
      if (eng_cnt > 0) eng_cnt--;
      else if (eng_cnt == 0) begin st_done = 1; st_idle = 1; eng_cnt = -1; end
      // Write address channel
      if (awready) begin
        awready = 0; aw_act = 0; wa_q.push_back(aw_hold);
      end else if (awvalid) begin
        if (!aw_act) begin aw_act = 1; aw_hold = awaddr; aw_dly = int'($urandom_range(0, MAXD)); end
        else if (awaddr !== aw_hold) unstable++;
        if (aw_dly == 0) awready = 1; else aw_dly--;
      end else if (aw_act) begin unstable++; aw_act = 0; end
      // Write data channel
      if (wready) begin
        wready = 0; w_act = 0; wd_q.push_back(w_hold);
      end else if (wvalid) begin
        if (!w_act) begin w_act = 1; w_hold = wdata; w_dly = int'($urandom_range(0, MAXD)); end
        else if (wdata !== w_hold) unstable++;
        if (w_dly == 0) wready = 1; else w_dly--;
      end else if (w_act) begin unstable++; w_act = 0; end
      while (wa_q.size() > 0 && wd_q.size() > 0) begin
        a = wa_q.pop_front(); d = wd_q.pop_front();
        wr_addr.push_back(a); wr_data.push_back(d);
        if (a == 12'h000) begin
          st_start = d[0];
          if (d[0]) begin st_idle = 0; st_done = 0; start_wr_cyc = cyc; eng_cnt = cfg_done_dly; end
        end else if (a >= 12'h040 && a < 12'h080) tap_mem[4'((a - 12'h040) >> 2)] = d;
      end
      // Read address / data channels
      if (arready) begin
        arready = 0; ar_act = 0; rd_addr.push_back(ar_hold);
        r_val = rd_value(ar_hold); r_pend = 1; r_dly = int'($urandom_range(0, MAXD));
      end else if (arvalid) begin
        if (!ar_act) begin ar_act = 1; ar_hold = araddr; ar_dly = int'($urandom_range(0, MAXD)); end
        else if (araddr !== ar_hold) unstable++;
        if (ar_dly == 0) arready = 1; else ar_dly--;
      end else if (ar_act) begin unstable++; ar_act = 0; end
      if (rvalid) rvalid = 0;
      else if (r_pend && rready) begin
        if (r_dly == 0) begin rvalid = 1; rdata = r_val; r_pend = 0; end else r_dly--;
      end
      // Coefficient source
      if (coef_ack) coef_ack = 0;
      else if (coef_req) begin
        if (c_dly < 0) c_dly = int'($urandom_range(0, MAXD));
        if (c_dly == 0) begin coef_ack = 1; coef_data = taps_cur[coef_idx]; c_dly = -1; end
        else c_dly--;
      end
    end
  end

  task automatic new_scen(input bit idle, input int done_dly, input int bad_idx);
    @(negedge axis_clk);
    cfg_idle     = idle;
    cfg_done_dly = done_dly;
    cfg_bad_en   = (bad_idx >= 0);
    cfg_bad_addr = 12'h040 + 12'(4 * ((bad_idx >= 0) ? bad_idx : 0));
    scen_id      = scen_id + 1;
    @(negedge axis_clk);
    @(negedge axis_clk);
  endtask

  task automatic pulse_start(input logic [31:0] len);
    cfg_len = len; cfg_start = 1;
    @(negedge axis_clk);
    cfg_start = 0; cfg_len = '0;
  endtask

  task automatic run(input string name, input logic [31:0] len, input bit idle,
                     input int done_dly, input int bad_idx, input int exp_code, input bit poke);
    logic [11:0] ea[$];
    logic [31:0] ed[$];
    logic [11:0] er[$];
    logic [11:0] tr[$];
    int ntaps, n, err_cyc, el;
    bit finished, quiet;
    if (exp_code != 1) begin
      ea.push_back(12'h010); ed.push_back(len);
      ntaps = (exp_code == 2) ? bad_idx + 1 : TAPS;
      for (int i = 0; i < ntaps; i++) begin
        ea.push_back(12'h040 + 12'(4 * i)); ed.push_back(taps_cur[i]);
        er.push_back(12'h040 + 12'(4 * i));
      end
      if (exp_code != 2) begin ea.push_back(12'h000); ed.push_back(32'h1); end
    end

    new_scen(idle, done_dly, bad_idx);
    @(negedge axis_clk);
    pulse_start(len);
    chk({name, " accept_busy"}, 64'(busy), 64'd1);
    chk({name, " accept_err_clr"}, 64'({err, err_code}), 64'd0);
    if (poke) begin
      for (int c = 0; c < 300 && !coef_req; c++) @(negedge axis_clk);
      pulse_start(~len);
    end
    finished = 0; err_cyc = 0;
    for (int c = 0; c < 4000 && !finished; c++) begin
      @(negedge axis_clk);
      if (done || err) begin finished = 1; err_cyc = cyc; end
    end
    quiet = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge axis_clk);
      if (awvalid || wvalid || arvalid || coef_req) quiet = 0;
    end
    chk({name, " finished"}, 64'(finished), 64'd1);
    chk({name, " err"}, 64'(err), 64'(exp_code != 0));
    chk({name, " err_code"}, 64'(err_code), 64'(exp_code));
    chk({name, " done_pulses"}, 64'(done_pulses), 64'(exp_code == 0));
    chk({name, " busy_after"}, 64'(busy), 64'd0);
    chk({name, " quiet_after"}, 64'(quiet), 64'd1);
    chk({name, " wr_count"}, 64'(wr_addr.size()), 64'(ea.size()));
    n = (wr_addr.size() < ea.size()) ? wr_addr.size() : ea.size();
    for (int i = 0; i < n; i++) begin
      chk({name, " wr_addr"}, 64'(wr_addr[i]), 64'(ea[i]));
      chk({name, " wr_data"}, 64'(wr_data[i]), 64'(ed[i]));
    end
    foreach (rd_addr[i]) if (rd_addr[i] != 12'h000) tr.push_back(rd_addr[i]);
    chk({name, " tap_rd_count"}, 64'(tr.size()), 64'(er.size()));
    n = (tr.size() < er.size()) ? tr.size() : er.size();
    for (int i = 0; i < n; i++) chk({name, " tap_rd_addr"}, 64'(tr[i]), 64'(er[i]));
    chk({name, " first_read"}, (rd_addr.size() > 0) ? 64'(rd_addr[0]) : 64'hfff, 64'h0);
    chk({name, " stable_hs"}, 64'(unstable), 64'd0);
    chk({name, " unpaired_hs"}, 64'(wa_q.size() + wd_q.size()), 64'd0);
    if (exp_code == 1) chk({name, " read_count"}, 64'(rd_addr.size()), 64'd1);
    if (exp_code == 3) begin
      el = err_cyc - start_wr_cyc;
      chk({name, " tmo_window"}, 64'(start_wr_cyc >= 0 && el >= TMO && el <= TMO + 20), 64'd1);
    end
  endtask

  task automatic rand_taps();
    for (int i = 0; i < 16; i++) taps_cur[i] = $urandom();
  endtask

  initial begin
    int          nom [TAPS];
    bit          quiet, seen;
    logic [31:0] rlen;
    nom = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    for (int i = 0; i < 16; i++) taps_cur[i] = '0;
    cfg_idle = 1; cfg_done_dly = 8; cfg_bad_en = 0; cfg_bad_addr = '0;
    axis_rst_n = 0; cfg_start = 0; cfg_len = '0;

    // Reset state
    repeat (3) @(negedge axis_clk);
    chk("rst valids", 64'({awvalid, wvalid, arvalid, rready, coef_req}), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst err", 64'(err), 64'd0);
    chk("rst err_code", 64'(err_code), 64'd0);
    axis_rst_n = 1;
    quiet = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge axis_clk);
      if (awvalid || wvalid || arvalid || coef_req || busy) quiet = 0;
    end
    chk("rst idle_no_traffic", 64'(quiet), 64'd1);

    // Nominal with the reference low-pass taps
    for (int i = 0; i < TAPS; i++) taps_cur[i] = 32'(nom[i]);
    run("nominal", 32'd64, 1, 8, -1, 0, 0);

    // Random lengths and taps, with cfg_start poked while busy
    for (int k = 0; k < 2; k++) begin
      rand_taps();
      run("random", $urandom(), 1, int'($urandom_range(2, 12)), -1, 0, 1);
    end

    // Engine not idle
    rand_taps();
    run("not_idle", 32'd64, 0, 8, -1, 1, 0);

    // Readback mismatch on 0x4C, then on a random tap including the last
    for (int i = 0; i < TAPS; i++) taps_cur[i] = 32'(nom[i]);
    run("mismatch3", 32'd64, 1, 8, 3, 2, 0);
    rand_taps();
    run("mismatch_rand", $urandom(), 1, 8, int'($urandom_range(0, TAPS - 1)), 2, 0);
    rand_taps();
    run("mismatch_last", $urandom(), 1, 8, TAPS - 1, 2, 0);

    // ap_done never arrives
    rand_taps();
    run("timeout", 32'd64, 1, -1, -1, 3, 0);

    // Reset in the middle of a transaction, then a clean recovery run
    rand_taps();
    rlen = $urandom();
    new_scen(1, 8, -1);
    @(negedge axis_clk);
    pulse_start(rlen);
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge axis_clk);
      if (awvalid) seen = 1;
    end
    chk("midrst saw_write", 64'(seen), 64'd1);
    #2 axis_rst_n = 0;
    #1;
    chk("midrst valids", 64'({awvalid, wvalid, arvalid, rready, coef_req}), 64'd0);
    chk("midrst busy", 64'(busy), 64'd0);
    repeat (2) @(negedge axis_clk);
    axis_rst_n = 1;
    repeat (4) @(negedge axis_clk);
    chk("midrst no_write_done", 64'(wr_addr.size()), 64'd0);
    chk("midrst idle", 64'({awvalid, wvalid, arvalid, busy}), 64'd0);
    rand_taps();
    run("recover", $urandom(), 1, int'($urandom_range(2, 12)), -1, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", ncmp);
    $fatal(1, "watchdog");
  end

endmodule
